// File: rtl/hsv_pkg.sv
// hsv_pkg: shared types and constants for the RGB -> HSV stream stage.
//   rgb_t / hsv_t : packed 3x8-bit pixel views ({R,G,B} and {H,S,V})
//   beat_t        : per-beat payload carried down the pipe (data, sop, eop, conv)
//   sel_t         : which channel supplied the maximum
//   HUE_BASE_*    : hue origin of each sector, HUE_SECTOR : hue span of one sector
//   RECIP_W       : width of reciprocal ROM entries, recip_of() gives floor(65536/d)
`timescale 1ns/1ps
package hsv_pkg;

    localparam int RECIP_W = 17;

    localparam logic [7:0] HUE_BASE_R = 8'd0;
    localparam logic [7:0] HUE_BASE_G = 8'd85;
    localparam logic [7:0] HUE_BASE_B = 8'd171;
    localparam logic [7:0] HUE_SECTOR = 8'd43;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] s;
        logic [7:0] v;
    } hsv_t;

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
        logic        conv;   // beat is to be replaced by its HSV value
    } beat_t;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } sel_t;

    // Reciprocal table entry; index 0 maps to 0 so that a zero max or
    // zero delta naturally yields a zero product.
    function automatic int recip_of(input int d);
        if (d == 0) begin
            return 0;
        end
        return 65536 / d;
    endfunction

endpackage

// File: rtl/hsv_recip_rom.sv
// hsv_recip_rom: 256 x RECIP_W reciprocal table, two synchronous read ports.
// Ports:
//   clk            clock
//   en             read enable; when low both read registers hold
//   addr_a/addr_b  8-bit read addresses
//   data_a/data_b  registered table contents, valid one cycle after the address
`timescale 1ns/1ps
module hsv_recip_rom #(
    parameter int RECIP_W = 17
) (
    input  logic               clk,
    input  logic               en,
    input  logic [7:0]         addr_a,
    input  logic [7:0]         addr_b,
    output logic [RECIP_W-1:0] data_a,
    output logic [RECIP_W-1:0] data_b
);

    logic [RECIP_W-1:0] rom [256];

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_rom
            assign rom[gi] = RECIP_W'(hsv_pkg::recip_of(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/rgb_hsv_stream.sv
// rgb_hsv_stream: Avalon-ST stage converting {R,G,B} video beats to {H,S,V}.
// Header beats and beats of non-video packets pass through bit-exact with the
// same fixed 4-beat latency. The whole pipe advances on en = source_ready | ~source_valid.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   sink_data/valid/ready/sop/eop       input stream, sink_data = {R,G,B}
//   source_data/valid/ready/sop/eop     output stream, source_data = {H,S,V} or the original beat
//   mode                                only with HSV_BYPASS_EN defined: 0 = pass beat through, 1 = convert
// Configuration macro: HSV_BYPASS_EN
`timescale 1ns/1ps
module rgb_hsv_stream #(
    parameter int RECIP_W = hsv_pkg::RECIP_W,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    output logic        sink_ready,
    input  logic        sink_sop,
    input  logic        sink_eop,
`ifdef HSV_BYPASS_EN
    input  logic        mode,
`endif
    output logic [23:0] source_data,
    output logic        source_valid,
    input  logic        source_ready,
    output logic        source_sop,
    output logic        source_eop
);
    import hsv_pkg::*;

    // One extra bit of headroom on each product for the rounding add.
    localparam int PS_W = 16 + RECIP_W + 1;
    localparam int PH_W = 14 + RECIP_W + 1;

    logic en;
    logic accept;
    logic mode_conv;

    assign en         = source_ready | ~source_valid;
    assign sink_ready = en;
    assign accept     = sink_valid & en;

`ifdef HSV_BYPASS_EN
    assign mode_conv = mode;
`else
    assign mode_conv = 1'b1;
`endif

    logic [LATENCY-1:0] vld_reg;
    logic               packet_video_reg;

    // ---------------- S1: max/min/delta/sector select/numerator ----------------
    rgb_t       pix;
    logic [7:0] max_c, min_c;
    sel_t       sel_c;
    logic [8:0] num_c;
    beat_t      beat_c;

    always_comb begin
        pix = sink_data;
        // Ties resolve R > G > B.
        if (pix.r >= pix.g && pix.r >= pix.b) begin
            sel_c = SEL_R;
            max_c = pix.r;
            num_c = {1'b0, pix.g} - {1'b0, pix.b};
        end else if (pix.g >= pix.b) begin
            sel_c = SEL_G;
            max_c = pix.g;
            num_c = {1'b0, pix.b} - {1'b0, pix.r};
        end else begin
            sel_c = SEL_B;
            max_c = pix.b;
            num_c = {1'b0, pix.r} - {1'b0, pix.g};
        end
        min_c = pix.r;
        if (pix.g < min_c) min_c = pix.g;
        if (pix.b < min_c) min_c = pix.b;
        beat_c.data = sink_data;
        beat_c.sop  = sink_sop;
        beat_c.eop  = sink_eop;
        // The packet flag register still holds the previous packet's type on a
        // sop beat, but sop beats are never converted anyway.
        beat_c.conv = ~sink_sop & packet_video_reg & mode_conv;
    end

    beat_t      s1_beat_reg, s2_beat_reg, s3_beat_reg;
    logic [7:0] s1_max_reg, s1_delta_reg;
    sel_t       s1_sel_reg, s2_sel_reg, s3_sel_reg;
    logic [8:0] s1_num_reg;

    // ---------------- S2: reciprocal lookups ----------------
    logic [RECIP_W-1:0] rom_max, rom_delta;
    logic [7:0]         s2_max_reg, s2_delta_reg, s2_mag_reg;
    logic               s2_neg_reg;

    hsv_recip_rom #(
        .RECIP_W (RECIP_W)
    ) u_recip_rom (
        .clk    (clk),
        .en     (en),
        .addr_a (s1_max_reg),
        .addr_b (s1_delta_reg),
        .data_a (rom_max),
        .data_b (rom_delta)
    );

    // ---------------- S3: multiplies ----------------
    logic [PS_W-1:0] s3_prod_s_reg;
    logic [PH_W-1:0] s3_prod_h_reg;
    logic [7:0]      s3_max_reg;
    logic            s3_neg_reg, s3_dzero_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            s1_beat_reg   <= beat_c;
            s1_max_reg    <= max_c;
            s1_delta_reg  <= max_c - min_c;
            s1_sel_reg    <= sel_c;
            s1_num_reg    <= num_c;

            s2_beat_reg   <= s1_beat_reg;
            s2_sel_reg    <= s1_sel_reg;
            s2_max_reg    <= s1_max_reg;
            s2_delta_reg  <= s1_delta_reg;
            s2_neg_reg    <= s1_num_reg[8];
            s2_mag_reg    <= s1_num_reg[8] ? 8'(-s1_num_reg) : s1_num_reg[7:0];

            s3_beat_reg   <= s2_beat_reg;
            s3_sel_reg    <= s2_sel_reg;
            s3_max_reg    <= s2_max_reg;
            s3_neg_reg    <= s2_neg_reg;
            s3_dzero_reg  <= (s2_delta_reg == 8'd0);
            s3_prod_s_reg <= PS_W'(s2_delta_reg) * PS_W'(8'd255) * PS_W'(rom_max);
            s3_prod_h_reg <= PH_W'(s2_mag_reg) * PH_W'(HUE_SECTOR) * PH_W'(rom_delta);
        end
    end

    // ---------------- S4: round, saturate, hue wrap, output mux ----------------
    logic [PS_W-1:0] s_round;
    logic [PH_W-1:0] h_round;
    logic [7:0]      sat_c, off_c, base_c;
    hsv_t            hsv_c;
    logic [23:0]     out_c;

    always_comb begin
        s_round = (s3_prod_s_reg + PS_W'(32768)) >> 16;
        sat_c   = (s_round > PS_W'(255)) ? 8'd255 : s_round[7:0];
        h_round = (s3_prod_h_reg + PH_W'(32768)) >> 16;
        off_c   = (h_round > PH_W'(255)) ? 8'd255 : h_round[7:0];
        case (s3_sel_reg)
            SEL_G:   base_c = HUE_BASE_G;
            SEL_B:   base_c = HUE_BASE_B;
            default: base_c = HUE_BASE_R;
        endcase
        hsv_c.v = s3_max_reg;
        hsv_c.s = sat_c;
        // 8-bit wrap gives the mod-256 hue for negative offsets.
        if (s3_dzero_reg) begin
            hsv_c.h = 8'd0;
        end else if (s3_neg_reg) begin
            hsv_c.h = base_c - off_c;
        end else begin
            hsv_c.h = base_c + off_c;
        end
        out_c = s3_beat_reg.conv ? hsv_c : s3_beat_reg.data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_reg          <= '0;
            packet_video_reg <= 1'b0;
            source_data      <= 24'd0;
            source_sop       <= 1'b0;
            source_eop       <= 1'b0;
        end else if (en) begin
            vld_reg     <= {vld_reg[LATENCY-2:0], accept};
            source_data <= out_c;
            source_sop  <= s3_beat_reg.sop & vld_reg[LATENCY-2];
            source_eop  <= s3_beat_reg.eop & vld_reg[LATENCY-2];
            if (accept && sink_sop) begin
                packet_video_reg <= (sink_data[3:0] == 4'h0);
            end
        end
    end

    assign source_valid = vld_reg[LATENCY-1];

endmodule

// File: tb/tb_rgb_hsv_stream.sv
`timescale 1ns/1ps
module tb_rgb_hsv_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] sink_data;
    logic        sink_valid;
    logic        sink_ready;
    logic        sink_sop;
    logic        sink_eop;
    logic [23:0] source_data;
    logic        source_valid;
    logic        source_ready;
    logic        source_sop;
    logic        source_eop;
    logic        mode_in;

    always #5 clk = ~clk;

    rgb_hsv_stream dut (
        .clk          (clk),
        .reset        (reset),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
`ifdef HSV_BYPASS_EN
        .mode         (mode_in),
`endif
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_sop   (source_sop),
        .source_eop   (source_eop)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] data;
        logic        sop;
        logic        eop;
        int          acc_cyc;
        bit          lat_chk;
        bit          lit_en;
        logic [23:0] lit;
    } exp_t;

    exp_t        q[$];
    exp_t        e_pop;
    exp_t        e_push;
    bit          tb_video = 0;
    bit          lit_en = 0;
    logic [23:0] lit_val = '0;
    bit          lat_mark = 0;
    bit          stalled = 0;
    logic [25:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference conversion from the plain HSV rules, integer arithmetic.
    function automatic logic [23:0] hsv_of(input logic [23:0] rgb);
        int r, g, b, mx, mn, d, rm, rd, s, h, num, base, off, mag;
        logic [7:0] h8, s8, v8;
        r = int'(rgb[23:16]);
        g = int'(rgb[15:8]);
        b = int'(rgb[7:0]);
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        d  = mx - mn;
        rm = (mx == 0) ? 0 : 65536 / mx;
        rd = (d == 0) ? 0 : 65536 / d;
        s  = (255 * d * rm + 32768) / 65536;
        if (s > 255) s = 255;
        if (r >= g && r >= b) begin
            num = g - b; base = 0;
        end else if (g >= b) begin
            num = b - r; base = 85;
        end else begin
            num = r - g; base = 171;
        end
        if (d == 0) begin
            h = 0;
        end else begin
            mag = (num < 0) ? -num : num;
            off = (43 * mag * rd + 32768) / 65536;
            h = base + ((num < 0) ? -off : off);
            h = ((h % 256) + 256) % 256;
        end
        h8 = 8'(h);
        s8 = 8'(s);
        v8 = 8'(mx);
        return {h8, s8, v8};
    endfunction

    // Single compare process: checks outputs on transfer, then records accepted inputs.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            tb_video = 0;
            stalled  = 0;
        end else begin
            if (stalled) begin
                chk("stall_hold", {source_valid, source_sop, source_eop, source_data},
                    {1'b1, held});
            end
            stalled = source_valid && !source_ready;
            held    = {source_sop, source_eop, source_data};

            if (source_valid && source_ready) begin
                out_count++;
                $display("OUT %0d cyc=%0d data=%06h sop=%b eop=%b",
                         out_count, cyc, source_data, source_sop, source_eop);
                if (q.size() == 0) begin
                    chk("unexpected_beat", {7'd0, source_valid, source_data}, 32'd0);
                end else begin
                    e_pop = q.pop_front();
                    chk("beat", {6'd0, source_sop, source_eop, source_data},
                        {6'd0, e_pop.sop, e_pop.eop, e_pop.data});
                    if (e_pop.lit_en) chk("literal", {8'd0, source_data}, {8'd0, e_pop.lit});
                    if (e_pop.lat_chk) chk("latency", cyc - e_pop.acc_cyc, 4);
                end
            end

            if (sink_valid && sink_ready) begin
                bit conv;
                conv = !sink_sop && tb_video;
`ifdef HSV_BYPASS_EN
                conv = conv && mode_in;
`endif
                e_push.data    = conv ? hsv_of(sink_data) : sink_data;
                e_push.sop     = sink_sop;
                e_push.eop     = sink_eop;
                e_push.acc_cyc = cyc;
                e_push.lat_chk = lat_mark;
                e_push.lit_en  = lit_en;
                e_push.lit     = lit_val;
                if (lit_en) chk("model_pin", {8'd0, e_push.data}, {8'd0, lit_val});
                if (sink_sop) tb_video = (sink_data[3:0] == 4'h0);
                q.push_back(e_push);
            end
        end
    end

    // Called and returning at posedge+1; holds the beat until accepted.
    task automatic send(input logic [23:0] d, input logic s, input logic e,
                        input bit le, input logic [23:0] l, input bit lc);
        bit ok;
        ok = 0;
        sink_data  = d;
        sink_sop   = s;
        sink_eop   = e;
        sink_valid = 1'b1;
        lit_en     = le;
        lit_val    = l;
        lat_mark   = lc;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sink_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        lit_en     = 0;
        lat_mark   = 0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || source_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", t, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_cnt;
        logic [7:0] iv;
        reset        = 1'b1;
        sink_data    = '0;
        sink_valid   = 1'b0;
        sink_sop     = 1'b0;
        sink_eop     = 1'b0;
        source_ready = 1'b1;
        mode_in      = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_valid", source_valid, 0);
        chk("reset_data", source_data, 0);
        chk("reset_sop", source_sop, 0);
        chk("reset_eop", source_eop, 0);
        @(posedge clk);
        #1;

        // Video packet: header, primaries, grey, ties, black, one general pixel
        send(24'h000000, 1, 0, 1, 24'h000000, 1);
        send(24'hFF0000, 0, 0, 1, 24'h00FFFF, 1);
        send(24'h00FF00, 0, 0, 1, 24'h55FFFF, 1);
        send(24'h0000FF, 0, 0, 1, 24'hABFFFF, 1);
        send(24'h808080, 0, 0, 1, 24'h000080, 1);
        send(24'hFFFF00, 0, 0, 1, 24'h2BFFFF, 1);
        send(24'hFF00FF, 0, 0, 1, 24'hD5FFFF, 1);
        send(24'hC86432, 0, 0, 1, 24'h0EBFC8, 1);
        send(24'h000000, 0, 1, 1, 24'h000000, 1);
        drain();

        // Non-video packet: every beat unchanged
        send(24'h00000F, 1, 0, 1, 24'h00000F, 0);
        send(24'h123456, 0, 0, 1, 24'h123456, 0);
        send(24'hFF0000, 0, 0, 1, 24'hFF0000, 0);
        send(24'hABCDEF, 0, 1, 1, 24'hABCDEF, 0);
        // Single-beat video packet
        send(24'h000000, 1, 1, 1, 24'h000000, 0);
        drain();

        // 640-beat line with a 10-cycle downstream stall in the middle
        base_cnt = out_count;
        fork
            begin
                send(24'h000000, 1, 0, 0, 24'h0, 0);
                for (int i = 1; i < 640; i++) begin
                    iv = 8'(i);
                    send({iv, 8'(i * 3), 8'(255 - i)}, 0, (i == 639), 0, 24'h0, 0);
                end
            end
            begin
                repeat (200) @(posedge clk);
                #1 source_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 source_ready = 1'b1;
            end
        join
        drain();
        chk("line_count", out_count - base_cnt, 640);

        // Reset mid-frame: in-flight beats are discarded
        send(24'h000000, 1, 0, 0, 24'h0, 0);
        send(24'h112233, 0, 0, 0, 24'h0, 0);
        send(24'h445566, 0, 0, 0, 24'h0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", source_valid, 0);
        @(posedge clk);
        #1;
        send(24'h000000, 1, 0, 1, 24'h000000, 1);
        send(24'hFF0000, 0, 0, 1, 24'h00FFFF, 1);
        send(24'h00FF00, 0, 1, 1, 24'h55FFFF, 1);
        drain();

`ifdef HSV_BYPASS_EN
        mode_in = 1'b0;
        send(24'h000000, 1, 0, 1, 24'h000000, 1);
        send(24'hFF0000, 0, 1, 1, 24'hFF0000, 1);
        drain();
        mode_in = 1'b1;
        send(24'h000000, 1, 0, 1, 24'h000000, 1);
        send(24'hFF0000, 0, 1, 1, 24'h00FFFF, 1);
        drain();
`endif

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
